// File: rtl/lp_problem_tx.sv
// Host-side transmitter for the LP solver frame protocol: stores one problem, serializes it, checks the reply.
// Optional WAIT watchdog compiled in with `define LP_TX_TIMEOUT_EN (limit = TIMEOUT cycles).
module lp_problem_tx #(
    parameter int NUM_CON = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [5:0]  ld_a1,
    input  logic [5:0]  ld_a2,
    input  logic [11:0] ld_b,
    output logic        ld_ready,
    input  logic [11:0] exp_value,
    input  logic        start,
    output logic        busy,
    output logic        tx_valid,
    output logic [5:0]  tx_a1,
    output logic [5:0]  tx_a2,
    output logic [11:0] tx_b,
    input  logic        rx_valid,
    input  logic [11:0] rx_max_value,
    output logic        done,
    output logic [11:0] result,
    output logic        match,
    output logic        timeout
);

    localparam int PW = $clog2(NUM_CON + 1);
    localparam logic [PW-1:0] LAST = PW'(NUM_CON);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t        state;
    logic [5:0]    a1_mem [0:NUM_CON];
    logic [5:0]    a2_mem [0:NUM_CON];
    logic [11:0]   b_mem  [0:NUM_CON];
    logic [PW-1:0] ptr;
    logic [PW-1:0] sidx;
    logic [PW-1:0] sidx_nx;
    logic          loaded;
    logic [11:0]   exp_lat;
    logic          launch;
    logic          ld_take;

`ifdef LP_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wcnt;
`else
    // The watchdog limit is meaningless without the watchdog.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout = 1'b0;
`endif

    // Load handshake: a word is taken on any edge with ld_valid && ld_ready, unless a
    // launching start shares that edge (start wins and the word is dropped).
    assign launch  = (state == IDLE) && start && loaded;
    assign ld_take = (state == IDLE) && ld_valid && !launch;
    assign sidx_nx = sidx + 1'b1;

    always_ff @(posedge clk) begin
        if (ld_take) begin
            a1_mem[ptr] <= ld_a1;
            a2_mem[ptr] <= ld_a2;
            b_mem[ptr]  <= ld_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sidx     <= '0;
            loaded   <= 1'b0;
            exp_lat  <= '0;
            ld_ready <= 1'b1;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_a1    <= '0;
            tx_a2    <= '0;
            tx_b     <= '0;
            done     <= 1'b0;
            result   <= '0;
            match    <= 1'b0;
`ifdef LP_TX_TIMEOUT_EN
            timeout  <= 1'b0;
            wcnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= SEND;
                        exp_lat  <= exp_value;
                        ld_ready <= 1'b0;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_a1    <= a1_mem[0];
                        tx_a2    <= a2_mem[0];
                        tx_b     <= '0;
                        sidx     <= '0;
                    end else if (ld_take) begin
                        if (ptr == '0) begin
                            loaded <= 1'b0;
                        end
                        if (ptr == LAST) begin
                            ptr    <= '0;
                            loaded <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (sidx == LAST) begin
                        state    <= WAIT;
                        tx_valid <= 1'b0;
                        tx_a1    <= '0;
                        tx_a2    <= '0;
                        tx_b     <= '0;
`ifdef LP_TX_TIMEOUT_EN
                        wcnt     <= '0;
`endif
                    end else begin
                        sidx  <= sidx_nx;
                        tx_a1 <= a1_mem[sidx_nx];
                        tx_a2 <= a2_mem[sidx_nx];
                        tx_b  <= b_mem[sidx_nx];
                    end
                end
                WAIT: begin
                    // A reply on the very edge the watchdog expires is still a normal capture.
                    if (rx_valid) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        result  <= rx_max_value;
                        match   <= (rx_max_value == exp_lat);
`ifdef LP_TX_TIMEOUT_EN
                        timeout <= 1'b0;
                    end else if (wcnt == WLAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        result  <= 12'h800;
                        match   <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lp_problem_tx.sv
// Scoreboard bench for lp_problem_tx: a queue-based frame/result model checked by a negedge monitor.
`timescale 1ns/1ps
module tb_lp_problem_tx;

    localparam int NUM_CON = 6;
    localparam int NW = NUM_CON + 1;
`ifdef LP_TX_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [5:0]  ld_a1;
    logic [5:0]  ld_a2;
    logic [11:0] ld_b;
    logic        ld_ready;
    logic [11:0] exp_value;
    logic        start;
    logic        busy;
    logic        tx_valid;
    logic [5:0]  tx_a1;
    logic [5:0]  tx_a2;
    logic [11:0] tx_b;
    logic        rx_valid;
    logic [11:0] rx_max_value;
    logic        done;
    logic [11:0] result;
    logic        match;
    logic        timeout;

    lp_problem_tx #(.NUM_CON(NUM_CON), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_a1(ld_a1), .ld_a2(ld_a2), .ld_b(ld_b), .ld_ready(ld_ready),
        .exp_value(exp_value), .start(start), .busy(busy),
        .tx_valid(tx_valid), .tx_a1(tx_a1), .tx_a2(tx_a2), .tx_b(tx_b),
        .rx_valid(rx_valid), .rx_max_value(rx_max_value),
        .done(done), .result(result), .match(match), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: the stored problem and what the solver link should see.
    logic [5:0]  m_a1 [NW];
    logic [5:0]  m_a2 [NW];
    logic [11:0] m_b  [NW];
    int          m_ptr;
    bit          m_loaded;
    logic [11:0] m_exp;
    logic [23:0] tx_q [$];
    logic [13:0] res_q [$];

    int checks = 0;
    int failures = 0;
    int run = 0;
    bit prev_done = 0;
    logic [23:0] tx_exp;
    logic [13:0] res_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic [5:0] a1, input logic [5:0] a2, input logic [11:0] b);
        m_a1[m_ptr] = a1;
        m_a2[m_ptr] = a2;
        m_b[m_ptr]  = b;
        m_loaded = (m_ptr == NUM_CON) || (m_loaded && m_ptr != 0);
        m_ptr = (m_ptr + 1) % NW;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_loaded = 0;
        tx_q.delete();
        res_q.delete();
    endtask

    task automatic load_word(input logic [5:0] a1, input logic [5:0] a2, input logic [11:0] b);
        ld_valid = 1'b1;
        ld_a1 = a1;
        ld_a2 = a2;
        ld_b = b;
        model_load(a1, a2, b);
        sync();
        ld_valid = 1'b0;
    endtask

    task automatic load_random_words(input int n);
        for (int w = 0; w < n; w++)
            load_word(6'($urandom), 6'($urandom), 12'($urandom));
    endtask

    task automatic load_spec_frame();
        load_word(6'd1, 6'd1, 12'd77);
        load_word(6'd1, 6'd0, 12'd5);
        load_word(6'(-1), 6'd0, 12'd0);
        load_word(6'd0, 6'd1, 12'd5);
        load_word(6'd0, 6'(-1), 12'd0);
        load_word(6'd1, 6'd1, 12'd8);
        load_word(6'd1, 6'(-1), 12'd3);
    endtask

    task automatic do_start(input logic [11:0] ev, input bit with_ld);
        start = 1'b1;
        exp_value = ev;
        if (with_ld) begin
            ld_valid = 1'b1;
            ld_a1 = 6'($urandom);
            ld_a2 = 6'($urandom);
            ld_b = 12'($urandom);
        end
        if (m_loaded) begin
            m_exp = ev;
            for (int i = 0; i < NW; i++)
                tx_q.push_back({m_a1[i], m_a2[i], (i == 0) ? 12'd0 : m_b[i]});
        end else if (with_ld) begin
            model_load(ld_a1, ld_a2, ld_b);
        end
        sync();
        start = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic drive_rx(input logic [11:0] v, input bit accept);
        rx_valid = 1'b1;
        rx_max_value = v;
        if (accept)
            res_q.push_back({v, v == m_exp, 1'b0});
        sync();
        rx_valid = 1'b0;
    endtask

    task automatic wait_frame_end();
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = !tx_valid && tx_q.size() == 0;
        end
        check("frame_drained", {31'd0, ok}, 32'd1);
        if (!ok)
            tx_q.delete();
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = res_q.size() == 0;
        end
        check("result_seen", {31'd0, ok}, 32'd1);
        if (!ok)
            res_q.delete();
        sync();
    endtask

    task automatic check_stays_idle(input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy || tx_valid)
                seen = 1;
        end
        check("start_ignored", {31'd0, seen}, 32'd0);
        sync();
    endtask

    // Monitor: every presented word and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            prev_done = 0;
        end else begin
            if (tx_valid) begin
                run++;
                if (tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got word %0h expected no word at %0t",
                             {tx_a1, tx_a2, tx_b}, $time);
                end else begin
                    tx_exp = tx_q.pop_front();
                    check("tx_word", {8'd0, tx_a1, tx_a2, tx_b}, {8'd0, tx_exp});
                end
            end else if (run != 0) begin
                check("frame_len", run, NW);
                check("tx_idle_data", {8'd0, tx_a1, tx_a2, tx_b}, 32'd0);
                run = 0;
            end
            if (prev_done)
                check("done_width", {31'd0, done}, 32'd0);
            if (done) begin
                check("busy_in_done", {31'd0, busy}, 32'd1);
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got result %0h expected no done at %0t",
                             result, $time);
                end else begin
                    res_exp = res_q.pop_front();
                    check("result", {18'd0, result, match, timeout}, {18'd0, res_exp});
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [11:0] ev;
        logic [11:0] v;
        rst = 1'b1;
        ld_valid = 1'b0;
        ld_a1 = '0;
        ld_a2 = '0;
        ld_b = '0;
        exp_value = '0;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_max_value = '0;
        m_exp = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {20'd0, result}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);

        // Reply while idle must not produce a done.
        drive_rx(12'd3, 0);
        sync();

        // Full frame, matching reply.
        load_spec_frame();
        do_start(12'd8, 0);
        wait_frame_end();
        sync();
        drive_rx(12'd8, 1);
        wait_done();

        // Resend without reload, mismatching reply.
        do_start(12'd8, 0);
        wait_frame_end();
        sync();
        drive_rx(12'd7, 1);
        wait_done();

        // Partial load keeps start from launching.
        load_random_words(4);
        do_start(12'd8, 0);
        check_stays_idle(5);
        load_random_words(3);
        ev = 12'($urandom);
        do_start(ev, 0);
        wait_frame_end();
        sync();
        drive_rx(ev, 1);
        wait_done();

        // Spurious reply during word 2, then real reply and a plain resend.
        load_spec_frame();
        do_start(12'd8, 0);
        sync();
        sync();
        drive_rx(12'd5, 0);
        wait_frame_end();
        sync();
        drive_rx(12'd8, 1);
        wait_done();
        do_start(12'd8, 0);
        wait_frame_end();
        sync();
        drive_rx(12'd8, 1);
        wait_done();

`ifdef LP_TX_TIMEOUT_EN
        begin
            int k;
            bit got;
            do_start(12'd8, 0);
            wait_frame_end();
            res_q.push_back({12'h800, 1'b0, 1'b1});
            k = 0;
            got = 0;
            while (k < 200 && !got) begin
                @(negedge clk);
                k++;
                got = done;
            end
            check("timeout_latency", k, TIMEOUT);
            sync();
        end
`else
        begin
            bit seen_done;
            do_start(12'd8, 0);
            wait_frame_end();
            seen_done = 0;
            repeat (120) begin
                @(negedge clk);
                if (done)
                    seen_done = 1;
            end
            check("wait_holds_busy", {30'd0, seen_done, busy}, 32'd1);
            sync();
            drive_rx(12'd8, 1);
            wait_done();
        end
`endif

        // Reset while word 3 is on the link.
        do_start(12'd8, 0);
        sync();
        sync();
        sync();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        sync();
        rst = 1'b0;
        do_start(12'd8, 0);
        check_stays_idle(5);
        load_random_words(NW);
        ev = 12'($urandom);
        do_start(ev, 0);
        wait_frame_end();
        sync();
        drive_rx(12'($urandom), 1);
        wait_done();

        // Randomized transactions.
        for (int it = 0; it < 25; it++) begin
            load_random_words(NW);
            ev = 12'($urandom);
            do_start(ev, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                sync();
                drive_rx(12'($urandom), 0);
            end
            wait_frame_end();
            sync();
            repeat ($urandom_range(0, 6)) begin
                if ($urandom_range(0, 2) == 0) begin
                    ld_valid = 1'b1;
                    ld_a1 = 6'($urandom);
                    ld_a2 = 6'($urandom);
                    ld_b = 12'($urandom);
                end
                sync();
                ld_valid = 1'b0;
            end
            v = ($urandom_range(0, 1) == 1) ? ev : 12'($urandom);
            drive_rx(v, 1);
            wait_done();
        end

        repeat (3) sync();
        check("tx_queue_empty", tx_q.size(), 32'd0);
        check("res_queue_empty", res_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
